// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and FSM state encoding for the sequential ALU
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AVG = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add multiplier, one multiplier bit per clock
module alu_seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic               running;

    // mcand is kept pre-shifted by cnt and mplier shifted down, so bit 0 is the current step
    always_comb begin
        prod_next = prod;
        if (mplier[0]) begin
            prod_next = prod + mcand;
        end
    end

    assign done   = running && (cnt == CNT_W'(WIDTH - 1));
    assign result = prod_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            prod    <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            cnt     <= '0;
            prod    <= '0;
            running <= 1'b1;
        end else if (running) begin
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt + 1'b1;
            prod    <= prod_next;
            running <= !done;
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - registered add/sub/mul/avg ALU with valid/ready handshakes
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 busy
);

    state_t             state_q;
    state_t             state_d;
    logic [2*WIDTH-1:0] y_q;
    logic [2*WIDTH-1:0] y_d;
    logic [WIDTH:0]     sum;
    logic               a_lt_b;
    logic [WIDTH-1:0]   diff_mag;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_result;

    assign sum      = {1'b0, a} + {1'b0, b};
    assign a_lt_b   = (a < b);
    assign diff_mag = a_lt_b ? (b - a) : (a - b);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .result (mul_result)
    );

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_DONE;
                    case (op)
                        OP_ADD: y_d = {{(WIDTH-1){1'b0}}, sum};
                        OP_SUB: y_d = {a_lt_b, {(WIDTH-1){1'b0}}, diff_mag};
                        OP_AVG: y_d = {sum[0], {(WIDTH-1){1'b0}}, sum[WIDTH:1]};
                        default: begin
                            mul_start = 1'b1;
                            state_d   = ST_MUL;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    y_d     = mul_result;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    assign y         = y_q;
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - self-checking bench for alu_seq_core at WIDTH=4 and WIDTH=8
module tb_alu_seq_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n4, rst_n8, iv4, iv8, out_ready;
    logic [7:0] a, b;
    logic [1:0] op;
    logic       ir4, ov4, busy4, ir8, ov8, busy8;
    logic [7:0] y4;
    logic [15:0] y8;

    alu_seq_core #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n4), .in_valid(iv4), .in_ready(ir4),
        .a(a[3:0]), .b(b[3:0]), .op(op), .out_valid(ov4),
        .out_ready(out_ready), .y(y4), .busy(busy4)
    );

    alu_seq_core #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .in_valid(iv8), .in_ready(ir8),
        .a(a), .b(b), .op(op), .out_valid(ov8),
        .out_ready(out_ready), .y(y8), .busy(busy8)
    );

    logic        sel8;
    logic        cur_ir, cur_ov, cur_busy;
    logic [15:0] cur_y;
    assign cur_ir   = sel8 ? ir8 : ir4;
    assign cur_ov   = sel8 ? ov8 : ov4;
    assign cur_busy = sel8 ? busy8 : busy4;
    assign cur_y    = sel8 ? y8 : {8'h00, y4};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_iv(input logic v);
        if (sel8) iv8 = v;
        else      iv4 = v;
    endtask

    function automatic logic [15:0] model(input int w, input int ta, input int tb_, input int top);
        int r;
        int s;
        s = ta + tb_;
        case (top)
            0: r = s;
            1: r = (ta >= tb_) ? (ta - tb_) : ((1 << (2*w - 1)) + (tb_ - ta));
            2: r = ta * tb_;
            default: r = ((s % 2) << (2*w - 1)) + (s / 2);
        endcase
        return 16'(r);
    endfunction

    task automatic run_op(input logic w8, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic [1:0] top, input logic [15:0] exp_y,
                          input int hold, input string name);
        int          lat;
        int          exp_lat;
        logic [15:0] ycap;
        sel8    = w8;
        exp_lat = (top == 2'b10) ? (w8 ? 9 : 5) : 1;
        @(negedge clk);
        check({name, " in_ready before accept"}, 32'(cur_ir), 32'd1);
        a = ta; b = tb_; op = top; out_ready = 1'b0;
        set_iv(1'b1);
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        while (!cur_ov && lat < 40) begin
            set_iv(1'($urandom_range(0, 1)));
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 2'($urandom);
            @(negedge clk);
            lat++;
        end
        set_iv(1'b0);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " y"}, 32'(cur_y), 32'(exp_y));
        ycap = cur_y;
        for (int h = 0; h < hold; h++) begin
            set_iv(1'b1);
            @(negedge clk);
            check({name, " held y"}, 32'(cur_y), 32'(ycap));
            check({name, " held valid/ready/busy"}, {29'd0, cur_ov, cur_ir, cur_busy}, 32'b101);
        end
        set_iv(1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        set_iv(1'b0);
        out_ready = 1'b0;
        check({name, " retire valid/ready"}, {30'd0, cur_ov, cur_ir}, 32'b01);
    endtask

    typedef struct {
        logic        w8;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  op;
        logic [15:0] y;
        int          hold;
        string       name;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int seen;
        rst_n4 = 1'b0; rst_n8 = 1'b0; iv4 = 1'b0; iv8 = 1'b0;
        out_ready = 1'b0; a = '0; b = '0; op = '0; sel8 = 1'b0;

        vecs[0] = '{1'b0, 8'd9,   8'd8,   2'b00, 16'h0011, 0, "add 9+8"};
        vecs[1] = '{1'b0, 8'd3,   8'd5,   2'b01, 16'h0082, 0, "sub 3-5"};
        vecs[2] = '{1'b0, 8'd6,   8'd6,   2'b01, 16'h0000, 0, "sub 6-6"};
        vecs[3] = '{1'b0, 8'd15,  8'd15,  2'b10, 16'h00E1, 0, "mul 15*15"};
        vecs[4] = '{1'b0, 8'd7,   8'd4,   2'b11, 16'h0085, 0, "avg 7,4"};
        vecs[5] = '{1'b0, 8'd15,  8'd15,  2'b11, 16'h000F, 0, "avg 15,15"};
        vecs[6] = '{1'b0, 8'd1,   8'd2,   2'b00, 16'h0003, 3, "add 1+2 hold"};
        vecs[7] = '{1'b0, 8'd15,  8'd15,  2'b00, 16'h001E, 0, "add 15+15"};
        vecs[8] = '{1'b1, 8'd255, 8'd255, 2'b10, 16'hFE01, 0, "w8 mul 255*255"};
        vecs[9] = '{1'b1, 8'd0,   8'd255, 2'b01, 16'h80FF, 1, "w8 sub 0-255"};

        @(posedge clk);
        @(negedge clk);
        check("reset w4 y", 32'(y4), 32'd0);
        check("reset w4 valid/ready/busy", {29'd0, ov4, ir4, busy4}, 32'b010);
        check("reset w8 y", 32'(y8), 32'd0);
        check("reset w8 valid/ready/busy", {29'd0, ov8, ir8, busy8}, 32'b010);
        rst_n4 = 1'b1;
        rst_n8 = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].w8, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].y,
                   vecs[i].hold, vecs[i].name);
        end

        for (int i = 0; i < 40; i++) begin
            int ra, rb, ro;
            ra = $urandom_range(0, 15);
            rb = $urandom_range(0, 15);
            ro = $urandom_range(0, 3);
            run_op(1'b0, 8'(ra), 8'(rb), 2'(ro), model(4, ra, rb, ro),
                   $urandom_range(0, 2), "rand w4");
        end
        for (int i = 0; i < 20; i++) begin
            int ra, rb, ro;
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            ro = $urandom_range(0, 3);
            run_op(1'b1, 8'(ra), 8'(rb), 2'(ro), model(8, ra, rb, ro),
                   $urandom_range(0, 2), "rand w8");
        end

        // reset asserted in the middle of a WIDTH=8 multiply
        sel8 = 1'b1;
        @(negedge clk);
        a = 8'd255; b = 8'd255; op = 2'b10; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        repeat (2) @(negedge clk);
        check("mid-mul busy before reset", 32'(busy8), 32'd1);
        #2 rst_n8 = 1'b0;
        #1;
        check("async reset y", 32'(y8), 32'd0);
        check("async reset valid/ready/busy", {29'd0, ov8, ir8, busy8}, 32'b010);
        @(negedge clk);
        rst_n8 = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (ov8) seen = 1;
        end
        check("no result after reset", 32'(seen), 32'd0);
        run_op(1'b1, 8'd255, 8'd255, 2'b10, 16'hFE01, 0, "w8 mul after reset");
        run_op(1'b1, 8'd200, 8'd3, 2'b10, 16'd600, 0, "w8 mul 200*3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised, registered successor to the combinational 4-bit ALU core.
- Same four operations (add, signed-magnitude subtract, multiply, average) and the same Y packing, generalised to WIDTH bits.
- Adds a valid/ready handshake on both sides, a registered output, and an iterative shift-add multiplier.
- Sits between the operand/opcode front-end and the result consumer. One operation is in flight at a time.

Parameters:
- WIDTH, 4, operand width in bits. Legal range is 2..16. Y is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), localparam. Width of the multiply step counter.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  operand/opcode offer.
- IN_READY  out  1  block can accept an operation.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned.
- OP  in  2  00 add, 01 subtract, 10 multiply, 11 average.
- OUT_VALID  out  1  Y holds a completed result.
- OUT_READY  in  1  consumer accepts Y.
- Y  out  2*WIDTH  registered result.
- BUSY  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (RST_N low, asynchronous, takes effect immediately in any state, including mid-multiply):
  - state=IDLE; Y=0, OUT_VALID=0, BUSY=0, IN_READY=1; step counter and partial product cleared.
  - The in-flight operation is discarded and no result is produced.
- States: IDLE, MUL, DONE.
- IDLE:
  - IN_READY=1.
  - Accept occurs on an edge with IN_VALID&IN_READY. A, B and OP are captured at that edge; later changes on the inputs are ignored.
  - OP 00/01/11: Y is computed and registered at the accept edge; next state DONE. OUT_VALID=1 from the following cycle (latency 1).
  - OP 10: next state MUL; counter=0; product register=0; multiplicand and multiplier latched.
- MUL:
  - IN_READY=0.
  - Each edge: if multiplier bit[counter] is set, add (multiplicand << counter) into the 2*WIDTH product register; then counter+1.
  - After WIDTH edges in MUL, Y=product, next state DONE. OUT_VALID rises WIDTH+1 edges after the accept edge.
- DONE:
  - OUT_VALID=1, IN_READY=0; Y is held stable.
  - On an edge with OUT_READY=1: next state IDLE and OUT_VALID=0. IN_READY=1 from the next cycle.
  - OUT_READY low holds DONE indefinitely.
  - Steady-state throughput: one non-multiply op per 2 cycles; one multiply per WIDTH+2 cycles.
- Arithmetic and Y packing, with S = A+B (WIDTH bits) and C = carry out:
  - add: Y = {zeros(WIDTH-1), C, S}.
  - subtract: D = A-B.
    - SIGN = 1 when A<B.
    - Y = {SIGN, zeros(WIDTH-1), |D|}.
    - A==B gives Y=0 with SIGN=0.
  - multiply: Y = A*B, full 2*WIDTH unsigned product. No overflow is possible.
  - average: Y = {S[0], zeros(WIDTH-1), C, S[WIDTH-1:1]}.
    - The low WIDTH bits hold floor((A+B)/2).
    - The MSB holds the remainder bit.
- Boundaries:
  - IN_VALID asserted while not IDLE is ignored; no accept and no error.
  - IN_VALID and OUT_READY asserted in the same cycle in DONE: only the output is retired. The new operation is accepted no earlier than the next cycle.
  - All-ones operands must not overflow any internal adder; internal adders are sized WIDTH+1 / 2*WIDTH.

Decomposition:
- Package alu_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_AVG=2'b11;
  - the state encoding (IDLE, MUL, DONE).
- One sub-module, alu_seq_mul, holds the iterative shift-add multiplier:
  - parameter WIDTH;
  - start/done strobes;
  - an internal counter and product register;
  - reset on RST_N.
- Add, subtract and average logic, the FSM and the output register stay in alu_seq_core.

Test Plan:
- WIDTH=4, add A=9 B=8, OUT_READY=1 -> OUT_VALID 1 cycle after accept, Y=8'h11. IN_READY high again 2 cycles after accept.
- WIDTH=4, subtract A=3 B=5 -> Y=8'h82. Then A=6 B=6 -> Y=8'h00.
- WIDTH=4, multiply A=15 B=15 -> OUT_VALID exactly 5 edges after accept, Y=8'hE1. IN_VALID pulses during MUL are not accepted.
- WIDTH=4, average A=7 B=4 -> Y=8'h85. Then A=15 B=15 -> Y=8'h0F.
- WIDTH=4, add A=1 B=2 with OUT_READY held low 3 cycles -> Y=8'h03 stable, OUT_VALID=1, IN_READY=0 throughout. Retired on the first OUT_READY edge.
- WIDTH=8, multiply A=255 B=255 -> Y=16'hFE01 after 9 edges. A second run with RST_N pulsed low at step 3 -> Y=0, OUT_VALID=0, state IDLE immediately, and no result is produced.
